// File: rtl/nibble_serializer.sv
// Framed LSB-first serial transmitter with a one-entry holding buffer.
// Each frame is a start bit, the data bits, an optional parity bit and a stop bit.
module nibble_serializer #(
  parameter int DATA_W     = 4,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int BIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              sout,
  output logic              busy,
  output logic              frame_done,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  localparam int              BW          = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0]   BIT_LAST    = BW'(DATA_W - 1);
  localparam logic [3:0]      CYC_LAST    = 4'(BIT_CYCLES - 1);
  localparam logic [3:0]      CYC_PRE     = 4'(BIT_CYCLES - 2);
  localparam logic            PAR_INIT    = (PARITY_ODD != 0);
  localparam logic            FD_ON_ENTRY = (BIT_CYCLES == 1);

  state_t              r_state;
  logic [DATA_W-1:0]   r_hold;
  logic                r_hold_full;
  logic [DATA_W-1:0]   r_shift;
  logic                r_par;
  logic [3:0]          r_cyc_cnt;
  logic [BW-1:0]       r_bit_cnt;
  logic                r_sout;
  logic                r_busy;
  logic                r_frame_done;

  logic                w_bit_end;
  logic                w_load;
  logic [DATA_W-1:0]   w_shift_nx;

  // Handshake: a word transfers on a rising edge with din_valid=1 and din_ready=1;
  // din_ready is the inverted hold_full flop and never depends on din_valid.
  assign din_ready  = ~r_hold_full;
  assign sout       = r_sout;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign dbg_state  = r_state;

  assign w_bit_end  = (r_cyc_cnt == CYC_LAST);
  assign w_shift_nx = r_shift >> 1;
  // Hold drains into the shift register from IDLE, or at the end of a stop bit.
  assign w_load     = r_hold_full &
                      ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));

  always_ff @(posedge clk) begin
    if (!clrn) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else if (w_load) begin
      r_hold_full <= 1'b0;
    end else if (din_valid && !r_hold_full) begin
      r_hold      <= din;
      r_hold_full <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      r_state      <= S_IDLE;
      r_shift      <= '0;
      r_par        <= 1'b0;
      r_cyc_cnt    <= '0;
      r_bit_cnt    <= '0;
      r_sout       <= 1'b1;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_sout       <= 1'b1;
          r_busy       <= 1'b0;
          r_frame_done <= 1'b0;
          if (w_load) begin
            r_state   <= S_START;
            r_shift   <= r_hold;
            r_par     <= (^r_hold) ^ PAR_INIT;
            r_cyc_cnt <= '0;
            r_bit_cnt <= '0;
            r_sout    <= 1'b0;
            r_busy    <= 1'b1;
          end
        end

        S_START: begin
          if (w_bit_end) begin
            r_state   <= S_DATA;
            r_cyc_cnt <= '0;
            r_sout    <= r_shift[0];
          end else begin
            r_cyc_cnt <= r_cyc_cnt + 4'd1;
          end
        end

        S_DATA: begin
          if (w_bit_end) begin
            r_cyc_cnt <= '0;
            r_shift   <= w_shift_nx;
            if (r_bit_cnt == BIT_LAST) begin
              r_bit_cnt <= '0;
              if (PARITY_EN != 0) begin
                r_state <= S_PARITY;
                r_sout  <= r_par;
              end else begin
                r_state      <= S_STOP;
                r_sout       <= 1'b1;
                r_frame_done <= FD_ON_ENTRY;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_sout    <= w_shift_nx[0];
            end
          end else begin
            r_cyc_cnt <= r_cyc_cnt + 4'd1;
          end
        end

        S_PARITY: begin
          if (w_bit_end) begin
            r_state      <= S_STOP;
            r_cyc_cnt    <= '0;
            r_sout       <= 1'b1;
            r_frame_done <= FD_ON_ENTRY;
          end else begin
            r_cyc_cnt <= r_cyc_cnt + 4'd1;
          end
        end

        S_STOP: begin
          if (w_bit_end) begin
            r_cyc_cnt    <= '0;
            r_frame_done <= 1'b0;
            if (w_load) begin
              // Next word is already waiting: start bit follows with no idle gap.
              r_state   <= S_START;
              r_shift   <= r_hold;
              r_par     <= (^r_hold) ^ PAR_INIT;
              r_bit_cnt <= '0;
              r_sout    <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              r_sout  <= 1'b1;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cyc_cnt    <= r_cyc_cnt + 4'd1;
            r_frame_done <= (r_cyc_cnt == CYC_PRE);
          end
        end

        default: begin
          r_state      <= S_IDLE;
          r_sout       <= 1'b1;
          r_busy       <= 1'b0;
          r_frame_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serializer.sv
// Directed bench for nibble_serializer: default, odd-parity and slow/no-parity
// instances, each driven with hand-computed serial streams.
module tb_nibble_serializer;

  logic       clk;
  logic       clrn;
  logic [3:0] din;
  logic       vld_def, vld_odd, vld_bc4;

  logic       rdy_def, sout_def, busy_def, fd_def;
  logic       rdy_odd, sout_odd, busy_odd, fd_odd;
  logic       rdy_bc4, sout_bc4, busy_bc4, fd_bc4;
  logic [2:0] st_def, st_odd, st_bc4;

  int n_total = 0;
  int n_bad   = 0;

  logic [0:0] exp_q[$];

  nibble_serializer u_def (
    .clk(clk), .clrn(clrn), .din(din), .din_valid(vld_def), .din_ready(rdy_def),
    .sout(sout_def), .busy(busy_def), .frame_done(fd_def), .dbg_state(st_def)
  );

  nibble_serializer #(.PARITY_ODD(1)) u_odd (
    .clk(clk), .clrn(clrn), .din(din), .din_valid(vld_odd), .din_ready(rdy_odd),
    .sout(sout_odd), .busy(busy_odd), .frame_done(fd_odd), .dbg_state(st_odd)
  );

  nibble_serializer #(.BIT_CYCLES(4), .PARITY_EN(0)) u_bc4 (
    .clk(clk), .clrn(clrn), .din(din), .din_valid(vld_bc4), .din_ready(rdy_bc4),
    .sout(sout_bc4), .busy(busy_bc4), .frame_done(fd_bc4), .dbg_state(st_bc4)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // bits[i] is the i-th serial bit on the line; each repeated rep times
  task automatic push_bits(input logic [15:0] bits, input int n, input int rep);
    for (int i = 0; i < n; i++)
      for (int r = 0; r < rep; r++)
        exp_q.push_back(bits[i]);
  endtask

  task automatic get_out(input int sel, output logic s, output logic b,
                         output logic f, output logic r);
    case (sel)
      0:       begin s = sout_def; b = busy_def; f = fd_def; r = rdy_def; end
      1:       begin s = sout_odd; b = busy_odd; f = fd_odd; r = rdy_odd; end
      default: begin s = sout_bc4; b = busy_bc4; f = fd_bc4; r = rdy_bc4; end
    endcase
  endtask

  task automatic set_vld(input int sel, input logic v);
    case (sel)
      0:       vld_def = v;
      1:       vld_odd = v;
      default: vld_bc4 = v;
    endcase
  endtask

  // drive one word; returns just after the accept edge E0
  task automatic send(input int sel, input logic [3:0] w, input string tag);
    logic s, b, f, r;
    din = w;
    set_vld(sel, 1'b1);
    tick();
    set_vld(sel, 1'b0);
    get_out(sel, s, b, f, r);
    chk({tag, "_acc_ready"}, r, 0);
    chk({tag, "_acc_idle"},  s, 1);
  endtask

  // check n line clocks against exp_q; frame_done expected on every fl-th clock
  task automatic run_frames(input int sel, input int n, input int fl, input string tag);
    logic s, b, f, r;
    logic [0:0] e;
    for (int c = 0; c < n; c++) begin
      tick();
      get_out(sel, s, b, f, r);
      e = exp_q.pop_front();
      chk({tag, "_sout"}, s, e);
      chk({tag, "_busy"}, b, 1);
      chk({tag, "_fdone"}, f, ((c + 1) % fl) == 0);
    end
    tick();
    get_out(sel, s, b, f, r);
    chk({tag, "_end_sout"}, s, 1);
    chk({tag, "_end_busy"}, b, 0);
    chk({tag, "_end_ready"}, r, 1);
    chk({tag, "_end_fdone"}, f, 0);
  endtask

  initial begin
    logic s, b, f, r;
    logic [0:0] e;

    // power-up reset with unknown inputs
    clrn = 1'b0; din = 'x; vld_def = 1'bx; vld_odd = 1'bx; vld_bc4 = 1'bx;
    tick();
    chk("rst_sout",  sout_def, 1);
    chk("rst_ready", rdy_def, 1);
    chk("rst_busy",  busy_def, 0);
    chk("rst_fdone", fd_def, 0);
    chk("rst_state", st_def, 0);
    chk("rst_bc4_ready", rdy_bc4, 1);
    tick();
    din = 4'h0; vld_def = 0; vld_odd = 0; vld_bc4 = 0;
    clrn = 1'b1;
    tick();
    chk("post_rst_sout", sout_def, 1);

    // 1011 even parity: 0,1,1,0,1,1,1
    send(0, 4'b1011, "w1011");
    push_bits(16'b1110110, 7, 1);
    run_frames(0, 7, 7, "w1011");

    // 0000 even parity: 0,0,0,0,0,0,1
    send(0, 4'b0000, "w0000e");
    push_bits(16'b1000000, 7, 1);
    run_frames(0, 7, 7, "w0000e");

    // 0000 odd parity: 0,0,0,0,0,1,1
    send(1, 4'b0000, "w0000o");
    push_bits(16'b1100000, 7, 1);
    run_frames(1, 7, 7, "w0000o");

    // back-to-back 1011 then 0110 with valid held
    din = 4'b1011; vld_def = 1'b1;
    tick();                          // E0
    chk("b2b_ready_e0", rdy_def, 0);
    din = 4'b0110;
    push_bits(16'b1110110, 7, 1);
    push_bits(16'b1001100, 7, 1);
    for (int c = 0; c < 14; c++) begin
      tick();
      e = exp_q.pop_front();
      chk("b2b_sout", sout_def, e);
      chk("b2b_busy", busy_def, 1);
      chk("b2b_fdone", fd_def, (c == 6) || (c == 13));
      chk("b2b_ready", rdy_def, (c == 0) || (c >= 7));
      if (c == 1) vld_def = 1'b0;    // second word taken on the edge just passed
    end
    tick();
    chk("b2b_end_sout", sout_def, 1);
    chk("b2b_end_busy", busy_def, 0);

    // BIT_CYCLES=4, no parity: 0,1,1,0,1,1 each x4
    send(2, 4'b1011, "bc4");
    push_bits(16'b110110, 6, 4);
    run_frames(2, 24, 24, "bc4");

    // reset during the 3rd data bit with a word waiting in hold
    send(0, 4'b1011, "rmid");
    tick();                          // E1 start bit
    chk("rmid_start", sout_def, 0);
    din = 4'b0110; vld_def = 1'b1;
    tick();                          // E2 data bit 0, second word accepted
    vld_def = 1'b0;
    chk("rmid_d0", sout_def, 1);
    chk("rmid_hold_ready", rdy_def, 0);
    tick();                          // E3 data bit 1
    tick();                          // E4 data bit 2
    chk("rmid_d2", sout_def, 0);
    clrn = 1'b0;
    vld_def = 1'b1;                  // ignored while in reset
    tick();
    chk("rmid_rst_sout",  sout_def, 1);
    chk("rmid_rst_busy",  busy_def, 0);
    chk("rmid_rst_ready", rdy_def, 1);
    chk("rmid_rst_fdone", fd_def, 0);
    vld_def = 1'b0;
    clrn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("rmid_idle_sout", sout_def, 1);
      chk("rmid_idle_busy", busy_def, 0);
    end

    // recovery after abort
    send(0, 4'b0000, "rec");
    push_bits(16'b1000000, 7, 1);
    run_frames(0, 7, 7, "rec");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
